// File: rtl/gci_std_display_register_bank_pkg.sv
// Shared register-map constants and request type for the display register bank.
package gci_std_display_register_bank_pkg;

  localparam logic [3:0] P_REG_ID        = 4'h0;
  localparam logic [3:0] P_REG_CTRL      = 4'h1;
  localparam logic [3:0] P_REG_BGCOLOR   = 4'h2;
  localparam logic [3:0] P_REG_STATUS    = 4'h3;
  localparam logic [3:0] P_REG_SEQ       = 4'h4;
  localparam logic [3:0] P_REG_IRQ_ENA   = 4'h5;
  localparam logic [3:0] P_REG_FRAME_CNT = 4'h6;

  localparam int P_STAT_VSYNC     = 0;
  localparam int P_STAT_UNDERFLOW = 1;

  localparam int P_CTRL_ENA      = 0;
  localparam int P_CTRL_MODE_LSB = 1;
  localparam int P_CTRL_MODE_MSB = 3;

  typedef struct packed {
    logic        rw;
    logic [3:0]  addr;
    logic [31:0] data;
  } ifReq_t;

endpackage

// File: rtl/gci_std_display_resp_fifo.sv
// Small synchronous FIFO; push while full is legal when a pop happens the same cycle.
module gci_std_display_resp_fifo #(
  parameter int P_DEPTH = 2,
  parameter int P_WIDTH = 32
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iFLUSH,
  input  logic               iPUSH,
  input  logic [P_WIDTH-1:0] iPUSH_DATA,
  input  logic               iPOP,
  output logic               oFULL,
  output logic               oEMPTY,
  output logic [P_WIDTH-1:0] oHEAD
);

  localparam int AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int CW = $clog2(P_DEPTH + 1);

  logic [P_DEPTH-1:0][P_WIDTH-1:0] mem;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic          doPush, doPop;

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == AW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign oFULL  = (count == CW'(P_DEPTH));
  assign oEMPTY = (count == '0);
  assign oHEAD  = mem[rdPtr];
  assign doPop  = iPOP && !oEMPTY;
  assign doPush = iPUSH && (!oFULL || doPop);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      mem   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (iFLUSH) begin
      mem   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= iPUSH_DATA;
        wrPtr      <= nextPtr(wrPtr);
      end
      if (doPop) rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gci_std_display_register_bank.sv
// Display-controller register file: control/colour regs, sticky events, frame counter,
// IRQ, and a buffered read-response path toward the hub interface.
module gci_std_display_register_bank
  import gci_std_display_register_bank_pkg::*;
#(
  parameter logic [31:0] P_ID       = 32'h4743_4931,
  parameter int          P_RESP_DEP = 2
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iIF_REQ,
  output logic        oIF_REQ_BUSY,
  input  logic        iIF_RW,
  input  logic [3:0]  iIF_ADDR,
  input  logic [31:0] iIF_DATA,
  output logic        oIF_VALID,
  input  logic        iIF_BUSY,
  output logic [31:0] oIF_DATA,
  input  logic        iVSYNC,
  input  logic        iUNDERFLOW,
  input  logic        iSEQ_BUSY,
  output logic        oCTRL_ENA,
  output logic [2:0]  oCTRL_MODE,
  output logic [23:0] oBGCOLOR,
  output logic        oIRQ
);

  logic [3:0]  ctrl;
  logic [23:0] bgColor;
  logic [1:0]  status;
  logic [1:0]  irqEna;
  logic [31:0] frameCnt;
  logic        irq;

  ifReq_t      req;
  logic        fifoFull, fifoEmpty;
  logic        accept, wrEn, rdPush, pop;
  logic [31:0] rdData;
  logic [1:0]  evSet, w1cMask;
  logic        unusedData;

  assign req        = '{rw: iIF_RW, addr: iIF_ADDR, data: iIF_DATA};
  assign unusedData = &{1'b0, req.data[31:24]};

  assign accept = iIF_REQ && !fifoFull;
  assign wrEn   = accept && req.rw;
  assign rdPush = accept && !req.rw;
  assign pop    = !fifoEmpty && !iIF_BUSY;

  // Read mux sees pre-edge state, so event-cycle reads return the old value.
  always_comb begin
    rdData = '0;
    case (req.addr)
      P_REG_ID:        rdData = P_ID;
      P_REG_CTRL:      rdData = 32'(ctrl);
      P_REG_BGCOLOR:   rdData = 32'(bgColor);
      P_REG_STATUS:    rdData = 32'(status);
      P_REG_SEQ:       rdData = 32'(iSEQ_BUSY);
      P_REG_IRQ_ENA:   rdData = 32'(irqEna);
      P_REG_FRAME_CNT: rdData = frameCnt;
      default:         rdData = '0;
    endcase
  end

  always_comb begin
    evSet                   = '0;
    evSet[P_STAT_VSYNC]     = iVSYNC;
    evSet[P_STAT_UNDERFLOW] = iUNDERFLOW;
  end
  assign w1cMask = (wrEn && req.addr == P_REG_STATUS) ? req.data[1:0] : 2'b00;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ctrl     <= '0;
      bgColor  <= '0;
      status   <= '0;
      irqEna   <= '0;
      frameCnt <= '0;
      irq      <= 1'b0;
    end else if (iRESET_SYNC) begin
      ctrl     <= '0;
      bgColor  <= '0;
      status   <= '0;
      irqEna   <= '0;
      frameCnt <= '0;
      irq      <= 1'b0;
    end else begin
      if (wrEn && req.addr == P_REG_CTRL)    ctrl    <= req.data[3:0];
      if (wrEn && req.addr == P_REG_BGCOLOR) bgColor <= req.data[23:0];
      if (wrEn && req.addr == P_REG_IRQ_ENA) irqEna  <= req.data[1:0];
      // Set after clear: a new event in the clearing cycle survives.
      status <= (status & ~w1cMask) | evSet;
      if (wrEn && req.addr == P_REG_FRAME_CNT) frameCnt <= '0;
      else if (iVSYNC)                         frameCnt <= frameCnt + 1'b1;
      irq <= |(status & irqEna);
    end
  end

  gci_std_display_resp_fifo #(
    .P_DEPTH (P_RESP_DEP),
    .P_WIDTH (32)
  ) uRespFifo (
    .iCLOCK     (iCLOCK),
    .inRESET    (inRESET),
    .iFLUSH     (iRESET_SYNC),
    .iPUSH      (rdPush),
    .iPUSH_DATA (rdData),
    .iPOP       (pop),
    .oFULL      (fifoFull),
    .oEMPTY     (fifoEmpty),
    .oHEAD      (oIF_DATA)
  );

  assign oIF_REQ_BUSY = fifoFull;
  assign oIF_VALID    = !fifoEmpty;
  assign oCTRL_ENA    = ctrl[P_CTRL_ENA];
  assign oCTRL_MODE   = ctrl[P_CTRL_MODE_MSB:P_CTRL_MODE_LSB];
  assign oBGCOLOR     = bgColor;
  assign oIRQ         = irq;

endmodule

// File: tb/tb_gci_std_display_register_bank.sv
// Scoreboard bench: driver pushes expected read data, negedge monitor pops on handshake.
module tb_gci_std_display_register_bank;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iRESET_SYNC = 1'b0;
  logic        iIF_REQ = 1'b0;
  logic        oIF_REQ_BUSY;
  logic        iIF_RW = 1'b0;
  logic [3:0]  iIF_ADDR = '0;
  logic [31:0] iIF_DATA = '0;
  logic        oIF_VALID;
  logic        iIF_BUSY = 1'b0;
  logic [31:0] oIF_DATA;
  logic        iVSYNC = 1'b0;
  logic        iUNDERFLOW = 1'b0;
  logic        iSEQ_BUSY = 1'b0;
  logic        oCTRL_ENA;
  logic [2:0]  oCTRL_MODE;
  logic [23:0] oBGCOLOR;
  logic        oIRQ;

  gci_std_display_register_bank dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iIF_REQ(iIF_REQ), .oIF_REQ_BUSY(oIF_REQ_BUSY), .iIF_RW(iIF_RW),
    .iIF_ADDR(iIF_ADDR), .iIF_DATA(iIF_DATA), .oIF_VALID(oIF_VALID),
    .iIF_BUSY(iIF_BUSY), .oIF_DATA(oIF_DATA), .iVSYNC(iVSYNC),
    .iUNDERFLOW(iUNDERFLOW), .iSEQ_BUSY(iSEQ_BUSY), .oCTRL_ENA(oCTRL_ENA),
    .oCTRL_MODE(oCTRL_MODE), .oBGCOLOR(oBGCOLOR), .oIRQ(oIRQ)
  );

  always #5 iCLOCK = ~iCLOCK;

  int tests = 0;
  int fails = 0;

  // Reference model: register contents as named fields, pending reads as a queue.
  logic [31:0] expQ[$];
  logic        mEna;
  logic [2:0]  mMode;
  logic [23:0] mBg;
  bit          mVsPend, mUfPend, mIrqVsEn, mIrqUfEn, mIrq;
  logic [31:0] mFrames;
  bit          bsy = 0;
  bit          seqLvl = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mReset();
    mEna = 0; mMode = 0; mBg = 0; mVsPend = 0; mUfPend = 0;
    mIrqVsEn = 0; mIrqUfEn = 0; mIrq = 0; mFrames = 0;
  endtask

  function automatic logic [31:0] mRead(input logic [3:0] a, input bit seq);
    case (a)
      4'h0: return 32'h4743_4931;
      4'h1: return {28'h0, mMode, mEna};
      4'h2: return {8'h0, mBg};
      4'h3: return {30'h0, mUfPend, mVsPend};
      4'h4: return {31'h0, seq};
      4'h5: return {30'h0, mIrqUfEn, mIrqVsEn};
      4'h6: return mFrames;
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: drive after posedge, settle model at negedge before the next edge.
  task automatic cyc(input bit req, input bit rw, input logic [3:0] addr, input logic [31:0] data,
                     input bit vs, input bit uf, input bit sync, output bit acc);
    bit nIrq;
    @(posedge iCLOCK); #1;
    iIF_REQ = req; iIF_RW = rw; iIF_ADDR = addr; iIF_DATA = data;
    iVSYNC = vs; iUNDERFLOW = uf; iRESET_SYNC = sync; iIF_BUSY = bsy; iSEQ_BUSY = seqLvl;
    @(negedge iCLOCK);
    check("outs", {35'h0, oCTRL_ENA, oCTRL_MODE, oBGCOLOR, oIRQ}, {35'h0, mEna, mMode, mBg, mIrq});
    acc = req && !oIF_REQ_BUSY && !sync;
    if (sync) begin
      mReset();
      expQ.delete();
    end else begin
      if (acc && !rw) expQ.push_back(mRead(addr, seqLvl));
      nIrq = (mVsPend && mIrqVsEn) || (mUfPend && mIrqUfEn);
      mVsPend = vs || (mVsPend && !(acc && rw && addr == 4'h3 && data[0]));
      mUfPend = uf || (mUfPend && !(acc && rw && addr == 4'h3 && data[1]));
      if (acc && rw && addr == 4'h6) mFrames = 0;
      else if (vs) mFrames = mFrames + 1;
      if (acc && rw && addr == 4'h1) begin mEna = data[0]; mMode = data[3:1]; end
      if (acc && rw && addr == 4'h2) mBg = data[23:0];
      if (acc && rw && addr == 4'h5) begin mIrqVsEn = data[0]; mIrqUfEn = data[1]; end
      mIrq = nIrq;
    end
  endtask

  task automatic rd(input logic [3:0] a);
    bit acc;
    cyc(1, 0, a, 32'h0, 0, 0, 0, acc);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bit acc;
    cyc(1, 1, a, d, 0, 0, 0, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, 32'h0, 0, 0, 0, acc);
  endtask

  // Monitor: a transfer happens at the next posedge when valid && !busy.
  always @(negedge iCLOCK) begin
    if (inRESET && oIF_VALID && !iIF_BUSY) begin
      if (expQ.size() == 0) begin
        tests++; fails++;
        $display("FAIL rdata: unexpected response %h with empty scoreboard", oIF_DATA);
      end else begin
        check("rdata", {32'h0, oIF_DATA}, {32'h0, expQ.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    mReset();
    repeat (3) @(posedge iCLOCK);
    @(negedge iCLOCK);
    check("rst_valid", {63'h0, oIF_VALID}, 64'h0);
    check("rst_busy", {63'h0, oIF_REQ_BUSY}, 64'h0);
    check("rst_outs", {32'h0, oIF_DATA}, 64'h0);
    inRESET = 1'b1;

    // ID read with latency 1, then CTRL read.
    rd(4'h0);
    cyc(0, 0, 4'h0, 32'h0, 0, 0, 0, acc);
    check("lat1", {63'h0, oIF_VALID}, 64'h1);
    rd(4'h1);
    idle(2);

    // CTRL write-all-ones then readback masked to 4 bits.
    wr(4'h1, 32'hFFFF_FFFF);
    rd(4'h1);
    wr(4'h2, 32'hA5C3_1E77);
    idle(2);

    // Back-pressure: 3 reads while hub busy, third held off.
    bsy = 1;
    rd(4'h0);
    rd(4'h2);
    cyc(1, 0, 4'h5, 32'h0, 0, 0, 0, acc);
    check("busy_full", {63'h0, oIF_REQ_BUSY}, 64'h1);
    check("held_off", {63'h0, acc}, 64'h0);
    bsy = 0;
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) cyc(1, 0, 4'h5, 32'h0, 0, 0, 0, acc);
    check("reissue", {63'h0, acc}, 64'h1);
    idle(3);

    // VSYNC flag, IRQ one cycle behind, set beats W1C.
    wr(4'h5, 32'h1);
    cyc(0, 0, 4'h0, 32'h0, 1, 0, 0, acc);
    rd(4'h3);
    idle(2);
    cyc(1, 1, 4'h3, 32'h1, 1, 0, 0, acc);
    rd(4'h3);
    wr(4'h3, 32'h3);
    rd(4'h3);
    cyc(0, 0, 4'h0, 32'h0, 0, 1, 0, acc);
    rd(4'h3);
    wr(4'h3, 32'h2);
    idle(2);

    // Frame counter wrap via preload, then write-wins on a VSYNC cycle.
    force dut.frameCnt = 32'hFFFF_FFFF;
    #1;
    release dut.frameCnt;
    mFrames = 32'hFFFF_FFFF;
    rd(4'h6);
    cyc(0, 0, 4'h0, 32'h0, 1, 0, 0, acc);
    rd(4'h6);
    cyc(0, 0, 4'h0, 32'h0, 1, 0, 0, acc);
    cyc(1, 1, 4'h6, 32'h1234, 1, 0, 0, acc);
    rd(4'h6);
    seqLvl = 1;
    rd(4'h4);
    seqLvl = 0;
    rd(4'h9);
    idle(2);

    // Sync reset with two responses buffered.
    bsy = 1;
    rd(4'h1);
    rd(4'h2);
    cyc(0, 0, 4'h0, 32'h0, 0, 0, 1, acc);
    cyc(0, 0, 4'h0, 32'h0, 0, 0, 0, acc);
    check("sync_valid", {63'h0, oIF_VALID}, 64'h0);
    check("sync_busy", {63'h0, oIF_REQ_BUSY}, 64'h0);
    check("sync_data", {32'h0, oIF_DATA}, 64'h0);
    bsy = 0;
    rd(4'h1);
    rd(4'h2);
    rd(4'h5);
    rd(4'h6);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bsy = ($urandom_range(0, 3) == 0);
      seqLvl = $urandom_range(0, 1) == 1;
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
          $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 0, acc);
    end

    bsy = 0;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) idle(1);
    check("drain", 64'(expQ.size()), 64'h0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
